vga_text_ctl: RTL and testbench

VGA_TEXT_CTL -- requirements
Module: vga_text_ctl

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_timing_gen.sv | 75 +++++++
 rtl/vga_text_ctl.sv | 199 +++++++++++++++++++
 tb/tb_vga_text_ctl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the VGA text controller slice.
//   rgb12_t      : 12-bit colour, R[11:8] G[7:4] B[3:0]
//   DEF_*        : default 640x480@60 timing (pixels / lines)
//   CURSOR_XOR   : mask applied to pixel_in on visible cursor pixels
//   vga_pipe_t   : per-pixel control bits carried through the delay pipeline
//   pipe_idle()  : pipeline stage value used on reset (blanked, sync idle)
// -----------------------------------------------------------------------------
package vga_pkg;

  typedef logic [11:0] rgb12_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam rgb12_t CURSOR_XOR = 12'hFFF;

  typedef struct packed {
    logic blank;
    logic hs;
    logic vs;
    logic fs;
    logic hit;
  } vga_pipe_t;

  function automatic vga_pipe_t pipe_idle(input logic sync_pol);
    vga_pipe_t s;
    s.blank = 1'b1;
    s.hs    = ~sync_pol;
    s.vs    = ~sync_pol;
    s.fs    = 1'b0;
    s.hit   = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Raster counters and undelayed timing decode for one clk_vga domain.
// Ports:
//   clk_vga, rst       : pixel clock, synchronous active-high reset
//   o_pixel_x/y        : current raster position (registered counters)
//   o_blank            : position outside the visible area
//   o_hs / o_vs        : sync levels (SYNC_POL when asserted)
//   o_frame_start      : position is (0,0)
//   o_frame_end        : position is the last pixel of the frame
// All decode outputs are combinational from the counters; the top delays them.
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk_vga,
  input  logic       rst,
  output logic [9:0] o_pixel_x,
  output logic [9:0] o_pixel_y,
  output logic       o_blank,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_frame_start,
  output logic       o_frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS     = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       w_line_end;

  assign w_line_end = (r_x == H_LAST);

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_line_end) begin
      r_x <= '0;
      r_y <= (r_y == V_LAST) ? '0 : r_y + 10'd1;
    end else begin
      r_x <= r_x + 10'd1;
    end
  end

  assign o_pixel_x     = r_x;
  assign o_pixel_y     = r_y;
  assign o_blank       = (r_x >= H_VIS) || (r_y >= V_VIS);
  assign o_hs          = ((r_x >= HS_START) && (r_x < HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign o_vs          = ((r_y >= VS_START) && (r_y < VS_END)) ? SYNC_POL : ~SYNC_POL;
  assign o_frame_start = (r_x == 10'd0) && (r_y == 10'd0);
  assign o_frame_end   = w_line_end && (r_y == V_LAST);

endmodule

// File: rtl/vga_text_ctl.sv
// -----------------------------------------------------------------------------
// vga_text_ctl
// Text-mode VGA front end: raster timing, a control delay pipeline aligned to
// the character generator's pixel latency, an optional blinking inverted
// cursor, and a colour-merging register on the character write path.
// Build option: define VGA_TEXT_CURSOR_EN to include the cursor and blink
// logic; without it the cursor inputs are accepted but ignored.
// Ports:
//   clk_vga, rst                 : pixel clock, synchronous active-high reset
//   clk_data                     : write-path clock (rst sampled directly)
//   char_we/char_addr/char_value : character write request
//   foreground_rgb/background_rgb: colours merged into plain 7-bit writes
//   mem_we/mem_addr/mem_wdata    : registered merged write to character memory
//   pixel_x/pixel_y              : raster position to the character generator
//   pixel_in                     : RGB for the position issued PIPE_DEPTH ago
//   cursor_en/col/row            : cursor control (clk_vga domain)
//   frame_start                  : one-cycle pulse aligned with pixel (0,0)
//   VGA_HS/VGA_VS/VGA_R/G/B      : display outputs
// -----------------------------------------------------------------------------
module vga_text_ctl
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE     = DEF_H_ACTIVE,
  parameter int   H_FP         = DEF_H_FP,
  parameter int   H_SYNC       = DEF_H_SYNC,
  parameter int   H_BP         = DEF_H_BP,
  parameter int   V_ACTIVE     = DEF_V_ACTIVE,
  parameter int   V_FP         = DEF_V_FP,
  parameter int   V_SYNC       = DEF_V_SYNC,
  parameter int   V_BP         = DEF_V_BP,
  parameter logic SYNC_POL     = 1'b0,
  parameter int   PIPE_DEPTH   = 2,
  parameter int   CHAR_W       = 8,
  parameter int   CHAR_H       = 16,
  parameter int   BLINK_FRAMES = 30
) (
  input  logic        clk_vga,
  input  logic        rst,
  input  logic        clk_data,
  input  logic        char_we,
  input  logic [11:0] char_addr,
  input  logic [31:0] char_value,
  input  rgb12_t      foreground_rgb,
  input  rgb12_t      background_rgb,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  input  rgb12_t      pixel_in,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [5:0]  cursor_row,
  output logic        frame_start,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B
);

  // ---------------------------------------------------------------------------
  // Write merge (clk_data). A value with nothing above bit 7 is a plain
  // character code: it gets the current default colours packed around it.
  // Anything wider is assumed to already carry its attributes.
  // ---------------------------------------------------------------------------
  logic [31:0] w_merged;

  assign w_merged = (char_value[31:8] == 24'd0)
                  ? {background_rgb, foreground_rgb, 1'b0, char_value[6:0]}
                  : char_value;

  always_ff @(posedge clk_data) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we    <= char_we;
      mem_addr  <= char_addr;
      mem_wdata <= w_merged;
    end
  end

  // ---------------------------------------------------------------------------
  // Raster timing
  // ---------------------------------------------------------------------------
  logic w_blank;
  logic w_hs;
  logic w_vs;
  logic w_frame_start;
  logic w_frame_end;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk_vga       (clk_vga),
    .rst           (rst),
    .o_pixel_x     (pixel_x),
    .o_pixel_y     (pixel_y),
    .o_blank       (w_blank),
    .o_hs          (w_hs),
    .o_vs          (w_vs),
    .o_frame_start (w_frame_start),
    .o_frame_end   (w_frame_end)
  );

  // ---------------------------------------------------------------------------
  // Cursor. The hit is evaluated against the live cursor inputs for the pixel
  // being issued, so moves take effect immediately. Blink visibility is folded
  // into the hit before it enters the pipeline.
  // ---------------------------------------------------------------------------
  logic w_cell_hit;

`ifdef VGA_TEXT_CURSOR_EN
  logic [7:0] r_blink_cnt;
  logic       r_blink_phase;
  logic       w_col_match;
  logic       w_row_match;

  // Counter runs regardless of cursor_en so toggling the enable never
  // restarts the blink cadence.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (w_frame_end) begin
      if (r_blink_cnt == 8'(BLINK_FRAMES - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 8'd1;
      end
    end
  end

  assign w_col_match = ((32'(pixel_x) / 32'(CHAR_W)) == 32'(cursor_col));
  assign w_row_match = ((32'(pixel_y) / 32'(CHAR_H)) == 32'(cursor_row));
  assign w_cell_hit  = !w_blank && cursor_en && r_blink_phase && w_col_match && w_row_match;
`else
  logic w_unused_cursor;
  assign w_unused_cursor = ^{cursor_en, cursor_col, cursor_row, w_frame_end};
  assign w_cell_hit      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control delay pipeline: the tail stage lines up with pixel_in.
  // Reset fills every stage with blanked / sync-idle values so the outputs
  // stay dark until real raster data has propagated through.
  // ---------------------------------------------------------------------------
  vga_pipe_t w_pipe_in;
  vga_pipe_t w_tail;
  vga_pipe_t r_pipe [PIPE_DEPTH];

  assign w_pipe_in.blank = w_blank;
  assign w_pipe_in.hs    = w_hs;
  assign w_pipe_in.vs    = w_vs;
  assign w_pipe_in.fs    = w_frame_start;
  assign w_pipe_in.hit   = w_cell_hit;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_pipe[i] <= pipe_idle(SYNC_POL);
      end
    end else begin
      r_pipe[0] <= w_pipe_in;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign w_tail = r_pipe[PIPE_DEPTH-1];

  // ---------------------------------------------------------------------------
  // Output colour: blanking wins over everything, then cursor inversion.
  // ---------------------------------------------------------------------------
  rgb12_t w_rgb;

  assign w_rgb = w_tail.blank ? 12'h000
               : (w_tail.hit ? (pixel_in ^ CURSOR_XOR) : pixel_in);

  assign VGA_R       = w_rgb[11:8];
  assign VGA_G       = w_rgb[7:4];
  assign VGA_B       = w_rgb[3:0];
  assign VGA_HS      = w_tail.hs;
  assign VGA_VS      = w_tail.vs;
  assign frame_start = w_tail.fs;

endmodule

// File: tb/tb_vga_text_ctl.sv
// -----------------------------------------------------------------------------
// tb_vga_text_ctl
// Small raster (H 8/2/2/2 = 14, V 6/1/1/1 = 9, 126 pixels per frame),
// PIPE_DEPTH 2, 4x3 character cells, BLINK_FRAMES 2, active-low sync.
// Drivers push expected responses into queues; monitors pop and compare one
// entry per clock after the active edge.
// -----------------------------------------------------------------------------
module tb_vga_text_ctl;

  localparam int PIPE    = 2;
  localparam int H_TOT   = 14;
  localparam int V_TOT   = 9;
  localparam int F_TOT   = H_TOT * V_TOT;
  localparam int RST_POS = 6 * F_TOT + 3 * H_TOT + 5;  // pixel (5,3) of frame 6

  // ---------------- clock / reset ----------------
  logic clk_vga  = 1'b0;
  logic clk_data = 1'b0;
  logic rst      = 1'b1;

  always #5 clk_vga  = ~clk_vga;
  always #6 clk_data = ~clk_data;

  // ---------------- DUT ----------------
  logic        char_we;
  logic [11:0] char_addr;
  logic [31:0] char_value;
  logic [11:0] foreground_rgb;
  logic [11:0] background_rgb;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [11:0] pixel_in;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        frame_start;
  logic        VGA_HS;
  logic        VGA_VS;
  logic [3:0]  VGA_R;
  logic [3:0]  VGA_G;
  logic [3:0]  VGA_B;

  vga_text_ctl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .PIPE_DEPTH(PIPE), .CHAR_W(4), .CHAR_H(3),
    .BLINK_FRAMES(2)
  ) dut (
    .clk_vga        (clk_vga),
    .rst            (rst),
    .clk_data       (clk_data),
    .char_we        (char_we),
    .char_addr      (char_addr),
    .char_value     (char_value),
    .foreground_rgb (foreground_rgb),
    .background_rgb (background_rgb),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .pixel_in       (pixel_in),
    .cursor_en      (cursor_en),
    .cursor_col     (cursor_col),
    .cursor_row     (cursor_row),
    .frame_start    (frame_start),
    .VGA_HS         (VGA_HS),
    .VGA_VS         (VGA_VS),
    .VGA_R          (VGA_R),
    .VGA_G          (VGA_G),
    .VGA_B          (VGA_B)
  );

  // ---------------- scoreboard state ----------------
  int n_pass  = 0;
  int n_total = 0;
  // pixel entry: {hs, vs, fs, rgb[11:0], pixel_x[9:0], pixel_y[9:0]}
  logic [34:0] exp_q[$];
  // write entry: {we_only, we, addr[11:0], data[31:0]}
  logic [45:0] exp_w_q[$];
  logic        w_done = 1'b0;
  int          obs_n  = 0;

  // Cursor inputs as a function of the raster position being issued:
  // frame 4 disables the cursor, frame 5 moves it to cell (0,1) for rows 3..5.
  function automatic logic [13:0] cur_in(input int p);
    int f, y;
    f = p / F_TOT;
    y = (p / H_TOT) % V_TOT;
    if (f == 4)            return {1'b0, 7'd1, 6'd0};
    if (f == 5 && y >= 3)  return {1'b1, 7'd0, 6'd1};
    return {1'b1, 7'd1, 6'd0};
  endfunction

  // Display outputs expected for raster position p (p < 0: pipeline still idle).
  function automatic logic [14:0] exp_disp(input int p);
    int x, y, f;
    logic blank, hs, vs, fs, hit, en;
    logic [6:0]  col;
    logic [5:0]  row;
    logic [11:0] rgb;
    if (p < 0) return {1'b1, 1'b1, 1'b0, 12'h000};
    x  = p % H_TOT;
    y  = (p / H_TOT) % V_TOT;
    f  = p / F_TOT;
    {en, col, row} = cur_in(p);
    blank = (x >= 8) || (y >= 6);
    hs    = !((x >= 10) && (x < 12));
    vs    = (y != 7);
    fs    = (x == 0) && (y == 0);
`ifdef VGA_TEXT_CURSOR_EN
    // visible in frames 0,1 / 4,5 / ... (half-period of two frames)
    hit = !blank && en && (((f / 2) % 2) == 0) && ((x / 4) == int'(col)) && ((y / 3) == int'(row));
`else
    hit = 1'b0;
    if (en && f < 0) hit = 1'b1;
`endif
    rgb = blank ? 12'h000 : (hit ? 12'hEDC : 12'h123);
    return {hs, vs, fs, rgb};
  endfunction

  function automatic logic [19:0] exp_pos(input int p);
    logic [9:0] x, y;
    x = 10'(p % H_TOT);
    y = 10'((p / H_TOT) % V_TOT);
    return {x, y};
  endfunction

  // ---------------- driver tasks ----------------
  // Called on a falling edge: sets inputs for the next rising edge at which the
  // counters present position k, and queues what must appear after that edge.
  task automatic drive_pix(input int k, input logic r);
    rst = r;
    {cursor_en, cursor_col, cursor_row} = cur_in(k);
    if (r) exp_q.push_back({exp_disp(-1), 20'd0});
    else   exp_q.push_back({exp_disp(k - (PIPE - 1)), exp_pos(k + 1)});
  endtask

  task automatic drive_wr(input logic we, input logic [11:0] addr, input logic [31:0] val,
                          input logic [11:0] fg, input logic [11:0] bg, input logic [31:0] exp_data);
    char_we        = we;
    char_addr      = addr;
    char_value     = val;
    foreground_rgb = fg;
    background_rgb = bg;
    exp_w_q.push_back({1'b0, we, addr, exp_data});
  endtask

  // ---------------- monitors ----------------
  initial begin
    logic [34:0] e, a;
    forever begin
      @(posedge clk_vga);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {VGA_HS, VGA_VS, frame_start, VGA_R, VGA_G, VGA_B, pixel_x, pixel_y};
        n_total++;
        if (a == e) n_pass++;
        else $display("FAIL pix obs=%0d act={hs,vs,fs,rgb,x,y}=%h exp=%h", obs_n, a, e);
        obs_n++;
      end
    end
  end

  initial begin
    logic [45:0] e;
    logic        ok;
    forever begin
      @(posedge clk_data);
      #1;
      if (exp_w_q.size() > 0) begin
        e = exp_w_q.pop_front();
        ok = e[45] ? (mem_we == e[44]) : ({mem_we, mem_addr, mem_wdata} == e[44:0]);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL wr act={we,addr,data}=%h exp=%h we_only=%0d",
                      {mem_we, mem_addr, mem_wdata}, e[44:0], e[45]);
      end
    end
  end

  // ---------------- write-path stimulus (clk_data) ----------------
  initial begin
    char_we        = 1'b1;
    char_addr      = 12'h3FF;
    char_value     = 32'h0000_0041;
    foreground_rgb = 12'h0F0;
    background_rgb = 12'h000;
    // write requested while in reset: nothing may be forwarded
    repeat (3) begin
      @(negedge clk_data);
      exp_w_q.push_back({1'b1, 1'b0, 12'h000, 32'h0});
    end
    wait (rst == 1'b0);
    char_we = 1'b0;
    @(negedge clk_data);
    drive_wr(1'b1, 12'h005, 32'h0000_0041, 12'h0F0, 12'h000, 32'h0000_F041);
    @(negedge clk_data);
    drive_wr(1'b1, 12'hABC, 32'h1234_56C1, 12'h0F0, 12'h000, 32'h1234_56C1);
    @(negedge clk_data);
    drive_wr(1'b0, 12'h010, 32'h0000_00C3, 12'hFFF, 12'h00F, 32'h00FF_FF43);
    @(negedge clk_data);
    drive_wr(1'b1, 12'hFFF, 32'h0000_00FF, 12'h123, 12'h456, 32'h4561_237F);
    @(negedge clk_data);
    drive_wr(1'b1, 12'h800, 32'h0000_0100, 12'h123, 12'h456, 32'h0000_0100);
    @(negedge clk_data);
    drive_wr(1'b0, 12'h800, 32'h0000_0100, 12'h123, 12'h456, 32'h0000_0100);
    @(negedge clk_data);
    @(negedge clk_data);
    w_done = 1'b1;
  end

  // ---------------- raster stimulus + summary ----------------
  initial begin
    pixel_in   = 12'h123;
    cursor_en  = 1'b0;
    cursor_col = 7'd0;
    cursor_row = 6'd0;
    // in reset: counters held at 0, outputs dark, sync idle
    repeat (4) begin
      @(negedge clk_vga);
      drive_pix(0, 1'b1);
    end
    // frames 0..6 up to pixel (5,3) of frame 6
    for (int k = 0; k < RST_POS; k++) begin
      @(negedge clk_vga);
      drive_pix(k, 1'b0);
    end
    // mid-frame reset
    repeat (2) begin
      @(negedge clk_vga);
      drive_pix(0, 1'b1);
    end
    // restart from (0,0); blink also restarts
    for (int k = 0; k < F_TOT + 14; k++) begin
      @(negedge clk_vga);
      drive_pix(k, 1'b0);
    end
    @(negedge clk_vga);
    @(negedge clk_vga);
    for (int i = 0; i < 200 && !w_done; i++) @(negedge clk_vga);
    if (!w_done) $display("FAIL wr_done timeout act=0 exp=1");
    repeat (3) @(negedge clk_vga);
    n_total++;
    if (exp_q.size() == 0 && exp_w_q.size() == 0) n_pass++;
    else $display("FAIL drain act=%0d/%0d exp=0/0", exp_q.size(), exp_w_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
